// File: rtl/tff_toggle_gen.sv
// Pushbutton front end for a T flip-flop: synchronises and debounces btn_in,
// then issues single-cycle toggle pulses on t (one per press, optional auto-repeat).
`timescale 1ns/1ps

module tff_toggle_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    input  logic             rpt_en,
    output logic             t,
    output logic             en,
    output logic             busy,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [1:0]       state_o
);

    localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    logic                   t_q, t_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   en_q;

    // The FSM only ever looks at the last synchroniser stage, never the raw pin.
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            t_q     <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, regardless of statement order.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            t_q     <= t_d;
            en_q    <= 1'b1;
            if (t_d) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        t_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB_PRESS;
                    dcnt_d  = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = HELD;
                    t_d     = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                // A release outranks a repeat that expires on the same edge.
                if (!s) begin
                    state_d = DEB_REL;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                end else if (rpt_en) begin
                    if (rcnt_q == RCNT_LAST) begin
                        t_d    = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end else begin
                    rcnt_d = '0;
                end
            end
            DEB_REL: begin
                if (s) begin
                    state_d = HELD;
                    rcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign t         = t_q;
    assign en        = en_q;
    assign busy      = (state_q != IDLE);
    assign pulse_cnt = cnt_q;
    assign state_o   = state_q;

endmodule
